// File: rtl/cache_ctrl.sv
// cache_ctrl: lookup/refill sequencer for a 2-way, 128-set tags file with 16-byte blocks.
// It drives the tags-file port, the block-fetch handshake and the data RAM write port.
module cache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_hit,
    output logic        resp_way,
    output logic [6:0]  tf_set_addr,
    output logic        tf_we,
    output logic        tf_set_element,
    output logic [12:0] tf_tag_in,
    output logic        tf_valid_in,
    input  logic [12:0] tf_tag_out0,
    input  logic [12:0] tf_tag_out1,
    input  logic        tf_valid_out0,
    input  logic        tf_valid_out1,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        dr_we,
    output logic [9:0]  dr_addr,
    output logic [31:0] dr_wdata,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEMREQ = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_TAGWR  = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    // Handshakes: a lookup transfers on a cycle with req_valid && req_ready (ready only in
    // IDLE); the fetch request holds mem_req/mem_addr until a cycle with mem_ack; each refill
    // word transfers on a cycle with mem_rvalid; resp_valid is a one-cycle pulse, no backpressure.

    logic [2:0]   state_q;
    logic [19:0]  addr_q;
    logic         victim_q;
    logic [1:0]   cnt_q;
    logic [127:0] lru_q;
    logic         resp_hit_q;
    logic         resp_way_q;
    logic         dr_we_q;
    logic [9:0]   dr_addr_q;
    logic [31:0]  dr_wdata_q;

    logic [12:0]  tag_q;
    logic [6:0]   set_q;
    logic         hit0;
    logic         hit1;
    logic         any_hit;
    logic         hit_way;
    logic         miss_victim;
    logic         unused_addr_bits;

    assign tag_q = addr_q[19:7];
    assign set_q = addr_q[6:0];

    // Byte/word offset is irrelevant to tag sequencing.
    assign unused_addr_bits = ^req_addr[3:0];

    always_comb begin
        hit0    = tf_valid_out0 && (tf_tag_out0 == tag_q);
        hit1    = tf_valid_out1 && (tf_tag_out1 == tag_q);
        any_hit = hit0 || hit1;
        hit_way = !hit0;
        if (!tf_valid_out0) begin
            miss_victim = 1'b0;
        end else if (!tf_valid_out1) begin
            miss_victim = 1'b1;
        end else begin
            miss_victim = lru_q[set_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            victim_q   <= 1'b0;
            cnt_q      <= '0;
            resp_hit_q <= 1'b0;
            resp_way_q <= 1'b0;
            dr_we_q    <= 1'b0;
            dr_addr_q  <= '0;
            dr_wdata_q <= '0;
        end else begin
            dr_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[23:4];
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (any_hit) begin
                        resp_hit_q <= 1'b1;
                        resp_way_q <= hit_way;
                        state_q    <= S_RESP;
                    end else begin
                        victim_q <= miss_victim;
                        state_q  <= S_MEMREQ;
                    end
                end
                S_MEMREQ: begin
                    if (mem_ack) begin
                        cnt_q   <= '0;
                        state_q <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_rvalid) begin
                        dr_we_q    <= 1'b1;
                        dr_addr_q  <= {set_q, victim_q, cnt_q};
                        dr_wdata_q <= mem_rdata;
                        cnt_q      <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= S_TAGWR;
                        end
                    end
                end
                S_TAGWR: begin
                    resp_hit_q <= 1'b0;
                    resp_way_q <= victim_q;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    resp_hit_q <= 1'b0;
                    resp_way_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The way just used becomes MRU, so the other way is next in line for eviction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_q <= '0;
        end else if (state_q == S_RESP) begin
            lru_q[set_q] <= ~resp_way_q;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = (state_q == S_RESP);
    assign resp_hit       = resp_hit_q;
    assign resp_way       = resp_way_q;
    assign tf_set_addr    = (state_q == S_IDLE) ? req_addr[10:4] : set_q;
    assign tf_we          = (state_q == S_TAGWR);
    assign tf_set_element = tf_we ? victim_q : 1'b0;
    assign tf_tag_in      = tf_we ? tag_q : 13'd0;
    assign tf_valid_in    = tf_we;
    assign mem_req        = (state_q == S_MEMREQ);
    assign mem_addr       = mem_req ? {addr_q, 4'b0000} : 24'd0;
    assign dr_we          = dr_we_q;
    assign dr_addr        = dr_addr_q;
    assign dr_wdata       = dr_wdata_q;
    assign state_dbg      = state_q;

    // Both ways matching the same tag means the tags file was corrupted upstream.
    a_single_hit_way: assert property (@(posedge clk) disable iff (!rst)
        (state_q == S_LOOKUP) |-> !(hit0 && hit1));

    a_mem_req_hold: assert property (@(posedge clk) disable iff (!rst)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr)));

    a_resp_pulse: assert property (@(posedge clk) disable iff (!rst)
        resp_valid |=> !resp_valid);

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and random lookups against cache_ctrl, with a tags-file model,
// a memory responder and a set-associative reference model of hits, victims and LRU.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [23:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_way;
    logic [6:0]  tf_set_addr;
    logic        tf_we;
    logic        tf_set_element;
    logic [12:0] tf_tag_in;
    logic        tf_valid_in;
    logic [12:0] tf_tag_out0;
    logic [12:0] tf_tag_out1;
    logic        tf_valid_out0;
    logic        tf_valid_out1;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        dr_we;
    logic [9:0]  dr_addr;
    logic [31:0] dr_wdata;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // Tags file: registered read one clk after the address, write forwarded to the read port.
    logic [12:0] tf_tag_arr [2][128];
    logic        tf_val_arr [2][128];
    logic        tf_flush;

    // Reference model state and scoreboard.
    logic [12:0] ref_tag [2][128];
    bit          ref_val [2][128];
    bit          ref_lru [128];
    logic [31:0] exp_q[$];
    logic [9:0]  exp_addr_q[$];
    time         last_resp_t;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .tf_set_addr(tf_set_addr), .tf_we(tf_we), .tf_set_element(tf_set_element),
        .tf_tag_in(tf_tag_in), .tf_valid_in(tf_valid_in),
        .tf_tag_out0(tf_tag_out0), .tf_tag_out1(tf_tag_out1),
        .tf_valid_out0(tf_valid_out0), .tf_valid_out1(tf_valid_out1),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dr_we(dr_we), .dr_addr(dr_addr), .dr_wdata(dr_wdata),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tf_flush) begin
            for (int s = 0; s < 128; s++) begin
                tf_val_arr[0][s] <= 1'b0;
                tf_val_arr[1][s] <= 1'b0;
                tf_tag_arr[0][s] <= '0;
                tf_tag_arr[1][s] <= '0;
            end
        end else if (tf_we) begin
            tf_tag_arr[tf_set_element][tf_set_addr] <= tf_tag_in;
            tf_val_arr[tf_set_element][tf_set_addr] <= tf_valid_in;
        end
        tf_tag_out0   <= (tf_we && !tf_set_element) ? tf_tag_in   : tf_tag_arr[0][tf_set_addr];
        tf_valid_out0 <= (tf_we && !tf_set_element) ? tf_valid_in : tf_val_arr[0][tf_set_addr];
        tf_tag_out1   <= (tf_we &&  tf_set_element) ? tf_tag_in   : tf_tag_arr[1][tf_set_addr];
        tf_valid_out1 <= (tf_we &&  tf_set_element) ? tf_valid_in : tf_val_arr[1][tf_set_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_dbg, 0);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_hit"}, resp_hit, 0);
        check({tag, "_resp_way"}, resp_way, 0);
        check({tag, "_tf_we"}, tf_we, 0);
        check({tag, "_tf_set_element"}, tf_set_element, 0);
        check({tag, "_tf_valid_in"}, tf_valid_in, 0);
        check({tag, "_tf_tag_in"}, tf_tag_in, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_dr_we"}, dr_we, 0);
        check({tag, "_dr_addr"}, dr_addr, 0);
    endtask

    // One lookup from accept to response (or to a reset injected before beat reset_at_beat).
    task automatic run_req(input logic [23:0] addr, input int ack_wait, input int gap_max,
                           input int reset_at_beat, output int lat, output logic way_out);
        logic [6:0]  s_idx;
        logic [12:0] tag;
        logic        h0, h1, exp_hit, exp_way, done;
        int          mem_cycles, ack_cyc, beats_driven, beats_seen, gap_left, last_rv_cyc;
        s_idx = addr[10:4];
        tag   = addr[23:11];
        h0 = ref_val[0][s_idx] && (ref_tag[0][s_idx] == tag);
        h1 = ref_val[1][s_idx] && (ref_tag[1][s_idx] == tag);
        exp_hit = h0 || h1;
        if (h0)                      exp_way = 1'b0;
        else if (h1)                 exp_way = 1'b1;
        else if (!ref_val[0][s_idx]) exp_way = 1'b0;
        else if (!ref_val[1][s_idx]) exp_way = 1'b1;
        else                         exp_way = ref_lru[s_idx];
        lat = -1; way_out = 1'b0; done = 1'b0;
        mem_cycles = 0; ack_cyc = -1; beats_driven = 0; beats_seen = 0; last_rv_cyc = -1;
        gap_left = 0;

        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        #1 check("tf_set_addr_accept", tf_set_addr, s_idx);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;

        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (mem_req) begin
                mem_cycles++;
                if (mem_cycles == 1) check("mem_req_first_cycle", cyc, 2);
                check("mem_addr", mem_addr, {tag, s_idx, 4'b0000});
            end
            if (dr_we) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("dr_we_unexpected", 1, 0);
                end else begin
                    check("dr_addr", dr_addr, exp_addr_q.pop_front());
                    check("dr_wdata", dr_wdata, exp_q.pop_front());
                end
            end
            if (tf_we) begin
                check("tf_set_element", tf_set_element, exp_way);
                check("tf_tag_in", tf_tag_in, tag);
                check("tf_set_addr_wr", tf_set_addr, s_idx);
                check("tf_valid_in", tf_valid_in, 1);
                check("tagwr_after_last_beat", cyc, last_rv_cyc + 1);
            end
            if (resp_valid) begin
                check("resp_hit", resp_hit, exp_hit);
                check("resp_way", resp_way, exp_way);
                check("resp_latency", cyc, exp_hit ? 2 : last_rv_cyc + 2);
                check("mem_req_cycles", mem_cycles, exp_hit ? 0 : ack_wait + 1);
                check("dr_we_count", beats_seen, exp_hit ? 0 : 4);
                lat = cyc; way_out = resp_way; done = 1'b1;
                last_resp_t = $time;
            end

            if (done) begin
                mem_ack = 1'b0; mem_rvalid = 1'b0;
            end else if (mem_req) begin
                mem_ack    = (mem_cycles == ack_wait + 1);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                if (mem_ack) begin
                    ack_cyc  = cyc;
                    gap_left = $urandom_range(0, gap_max);
                end
            end else if (ack_cyc >= 0 && beats_driven < 4) begin
                mem_ack = 1'b0;
                if (reset_at_beat >= 0 && beats_driven == reset_at_beat) begin
                    rst = 1'b0; mem_rvalid = 1'b0;
                    #1 check_reset_outputs("midreset");
                    exp_q.delete();
                    exp_addr_q.delete();
                    for (int s = 0; s < 128; s++) ref_lru[s] = 1'b0;
                    @(negedge clk);
                    check_reset_outputs("midreset_held");
                    rst = 1'b1;
                    done = 1'b1;
                end else if (gap_left > 0) begin
                    gap_left--;
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                    exp_q.push_back(mem_rdata);
                    exp_addr_q.push_back({s_idx, exp_way, beats_driven[1:0]});
                    beats_driven++;
                    if (beats_driven == 4) last_rv_cyc = cyc;
                    gap_left = $urandom_range(0, gap_max);
                end
            end else begin
                mem_ack = 1'b0; mem_rvalid = 1'b0;
            end
        end

        if (!done) begin
            check("resp_timeout", 0, 1);
        end else if (lat >= 0) begin
            if (!exp_hit) begin
                ref_tag[exp_way][s_idx] = tag;
                ref_val[exp_way][s_idx] = 1'b1;
            end
            ref_lru[s_idx] = ~exp_way;
        end
    endtask

    initial begin
        int   lat;
        logic way;
        time  t_a;
        logic [23:0] a;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; tf_flush = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1; tf_flush = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Cold miss with minimum latency.
        run_req(24'h000010, 0, 0, -1, lat, way);
        check("cold_miss_latency", lat, 8);
        check("cold_miss_way", way, 0);
        // Hit on the block just filled.
        run_req(24'h000010, 0, 0, -1, lat, way);
        check("repeat_hit_latency", lat, 2);
        // Same set, new tags: fill the invalid way, then evict by LRU.
        run_req(24'h000810, 0, 0, -1, lat, way);
        check("second_tag_way", way, 1);
        run_req(24'h001010, 0, 0, -1, lat, way);
        check("lru_evict_way", way, 0);
        // Back-to-back hits, one response every 3 cycles.
        run_req(24'h000810, 0, 0, -1, lat, way);
        t_a = last_resp_t;
        run_req(24'h001010, 0, 0, -1, lat, way);
        check("b2b_hit_spacing", 32'(last_resp_t - t_a), 30);
        // Slow ack and gapped refill beats.
        run_req(24'h0A0B20, 5, 3, -1, lat, way);
        run_req(24'h0A0B24, 0, 0, -1, lat, way);
        check("slow_fill_hit", lat, 2);
        // Reset in the middle of the refill, then a fresh lookup.
        run_req(24'h123450, 1, 1, 2, lat, way);
        check("aborted_no_resp", lat, -1);
        run_req(24'h123450, 0, 1, -1, lat, way);
        check("post_reset_miss_way", way, 0);
        // Cleared LRU must pick way 0 in a full set.
        run_req(24'h001810, 0, 0, -1, lat, way);
        check("lru_cleared_victim", way, 0);

        for (int i = 0; i < 40; i++) begin
            a = {13'($urandom_range(0, 3)), 7'($urandom_range(2, 5)), 4'($urandom_range(0, 15))};
            run_req(a, $urandom_range(0, 3), $urandom_range(0, 2), -1, lat, way);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the 2-way set-associative tags file: 128 sets, 13-bit tags, 16-byte blocks. Accepts one CPU read lookup at a time, drives the tags-file read port, and compares both ways. On a miss it picks a victim (invalid way first, else LRU), fetches the 4-word block over a memory handshake, and writes the data RAM and then the tag/valid entry. Sits between the CPU fetch/load stage, the tags file, the cache data RAM and the memory interface.

## Interface
- No parameters. Geometry is fixed: addr[23:11] is the tag, addr[10:4] the set, addr[3:2] the word.
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU lookup request
- req_addr  in  24  CPU byte address
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready
- resp_valid  out  1  one-cycle pulse per accepted request
- resp_hit  out  1  1 means hit, 0 means the response follows a completed refill
- resp_way  out  1  way holding the block
- tf_set_addr  out  7  tags-file set address; read data appears one clk later
- tf_we  out  1  tags-file write enable
- tf_set_element  out  1  way to write
- tf_tag_in  out  13  tag to write
- tf_valid_in  out  1  valid bit to write; always 1
- tf_tag_out0, tf_tag_out1  in  13  tags of way 0 and way 1
- tf_valid_out0, tf_valid_out1  in  1  valid bits of way 0 and way 1
- mem_req  out  1  block fetch request
- mem_addr  out  24  block-aligned address, {tag, set, 4'b0}
- mem_ack  in  1  memory accepted the request
- mem_rvalid  in  1  one refill word delivered this cycle
- mem_rdata  in  32  refill word
- dr_we  out  1  data RAM write strobe
- dr_addr  out  10  {set, way, word}
- dr_wdata  out  32  equals mem_rdata

## Operation
- States: IDLE, LOOKUP, MEMREQ, REFILL, TAGWR, RESP.
- IDLE
  - req_ready = 1 and tf_set_addr = req_addr[10:4] (combinational), so the tags-file read launches in the accept cycle.
  - On accept: latch addr_q and go to LOOKUP.
- LOOKUP
  - tf_set_addr is held at addr_q set.
  - hit0 = tf_valid_out0 & (tf_tag_out0 == addr_q tag); hit1 likewise for way 1.
  - On any hit, go to RESP with hit=1. Way = 0 if hit0, else 1; hit0 wins if both match, which is a protocol error that only the assertion flags.
  - On a miss, select the victim: !valid0 gives way 0; else !valid1 gives way 1; else lru[set]. Go to MEMREQ.
- MEMREQ
  - mem_req = 1 and mem_addr stable until the cycle mem_ack = 1, then go to REFILL with word counter = 0.
  - mem_rvalid is ignored in this state.
- REFILL
  - On each mem_rvalid: dr_we = 1, dr_addr = {set, victim, cnt}, then cnt++.
  - Beats arrive in order, words 0 to 3. The critical word is not returned early.
  - After beat 3, go to TAGWR.
- TAGWR
  - One cycle: tf_we = 1, tf_set_element = victim, tf_set_addr = set, tf_tag_in = tag, tf_valid_in = 1.
  - Then go to RESP with hit=0 and way = victim.
- RESP
  - resp_valid = 1 for one cycle, with resp_hit and resp_way valid.
  - Update the LRU bit: lru[set] = ~way, so the accessed way becomes MRU. This applies to both hits and refills.
  - Go to IDLE.
- LRU: 128 one-bit flops, all 0 at reset, written only in RESP.
- A miss refill always runs to completion. There is no abort input.

## Timing
- Reset values while rst = 0 and after release:
  - state IDLE, req_ready 1.
  - resp_valid, resp_hit, resp_way, tf_we, tf_set_element, tf_valid_in, mem_req, dr_we all 0.
  - tf_tag_in, mem_addr, dr_addr 0; lru all 0; cnt 0.
- Reset mid-operation forces IDLE asynchronously and drops mem_req at once. Memory is expected to be reset by the same rst.
- Hit latency: accept at cycle 0, compare at cycle 1, resp_valid at cycle 2. Back-to-back hits give one response every 3 cycles.
- Miss latency: 1 (LOOKUP) + MEMREQ cycles up to and including mem_ack + cycles until the 4th rvalid + 1 (TAGWR) + 1 (RESP).
- mem_ack in the first MEMREQ cycle is legal; the minimum miss is 8 cycles with 4 back-to-back rvalids.
- The request following a refill of the same set reads the updated tag. The tags file forwards the write, so no stall is needed.
- Outputs are decoded from state and latched data only. No input-to-output combinational path exists except req_addr to tf_set_addr in IDLE.

## Test plan
- Reset then lookup 0x000010 with all sets invalid:
  - mem_addr 0x000010 and victim way 0.
  - Four dr_we with dr_addr {1,0,0..3}.
  - tf_we with tag 0, set_element 0.
  - resp_hit 0, way 0; lru[1] = 1.
- Repeat 0x000010 → resp_valid at cycle 2 with hit 1, way 0, and no mem_req.
- Addresses 0x000810 and 0x001010 (same set 1, tags 1 and 2) after the first test:
  - 0x000810 fills way 1.
  - 0x001010 evicts way 0, because lru[1] = 0 after the way-1 access.
- Hold mem_ack low for 5 cycles → mem_req and mem_addr stay stable throughout, and no dr_we fires.
- Gaps between the rvalid beats → dr_addr word index increments only on mem_rvalid. TAGWR comes exactly one cycle after the 4th beat.
- Assert rst low during REFILL beat 2:
  - Outputs return to their reset values immediately and lru clears.
  - The next request starts a fresh lookup.
